// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-requester ROM arbiter.
// Contents: default ROM geometry, arbiter state encoding, requester ids.
package rom_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 3;
   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rom.sv
// 8 x 8 registered-read ROM with enable-gated read.
// Ports: clk, en read enable, addr read address, data registered read data
//        (updated one edge after en=1, holds otherwise).
module rom
   import rom_arb_pkg::*;
(
   input  logic                  clk,
   input  logic                  en,
   input  logic [DEF_ADDR_W-1:0] addr,
   output logic [DEF_DATA_W-1:0] data
);

   function automatic logic [DEF_DATA_W-1:0] rom_word(input logic [DEF_ADDR_W-1:0] a);
      case (a)
         3'd0:    rom_word = 8'h5A;
         3'd1:    rom_word = 8'hC3;
         3'd2:    rom_word = 8'h17;
         3'd3:    rom_word = 8'hE8;
         3'd4:    rom_word = 8'h99;
         3'd5:    rom_word = 8'h26;
         3'd6:    rom_word = 8'hF0;
         default: rom_word = 8'h4B;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (en) data <= rom_word(addr);
   end

endmodule

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
// Ports: req[1:0] request vector, ptr favoured requester (0 or 1),
//        win_c[1:0] one-hot winner (all zero when nothing is requested).
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] win_c
);

   // A lone request passes straight through; the pointer only breaks ties.
   always_comb begin
      win_c = 2'b00;
      if (req == 2'b11) win_c = ptr ? 2'b10 : 2'b01;
      else              win_c = req;
   end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM between two requesters.
// Each access takes a fixed three cycles: grant/issue, capture, valid.
// Ports: clk, rst (sync, active high); req0/addr0/gnt0/vld0 and
//        req1/addr1/gnt1/vld1 requester handshakes; rdata shared read data;
//        busy high while an access is in flight; rom_en/rom_addr/rom_data
//        connect to the ROM.
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              vld0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic              vld1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   state_t     state;
   logic       ptr;
   logic       win_id;
   logic [1:0] win_c;

   // Pointer lives here so it only moves when an access completes.
   rr_arb2 u_arb (
      .req   ({req1, req0}),
      .ptr   (ptr),
      .win_c (win_c)
   );

   // Access sequencer; requests are only looked at in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= REQ0;
         win_id   <= REQ0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         vld0     <= 1'b0;
         vld1     <= 1'b0;
         busy     <= 1'b0;
         rom_en   <= 1'b0;
         rdata    <= '0;
         rom_addr <= '0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         vld0 <= 1'b0;
         vld1 <= 1'b0;
         case (state)
            IDLE: begin
               if (win_c != 2'b00) begin
                  gnt0     <= win_c[0];
                  gnt1     <= win_c[1];
                  win_id   <= win_c[1];
                  rom_addr <= win_c[1] ? addr1 : addr0;
                  rom_en   <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               rom_en <= 1'b0;
               state  <= CAPTURE;
            end
            CAPTURE: begin
               rdata <= rom_data;
               vld0  <= (win_id == REQ0);
               vld1  <= (win_id == REQ1);
               busy  <= 1'b0;
               ptr   <= ~win_id;
               state <= IDLE;
            end
            default: begin
               rom_en <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter driving the real rom.
// A timeline model schedules the expected outputs of each accepted request
// into per-cycle tables; a compare process checks them every cycle while
// directed tests pin key cycles with literal values.
module tb_rom_arbiter;

   localparam int N = 1024;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [2:0] addr0 = 3'd0, addr1 = 3'd0;
   logic       gnt0, gnt1, vld0, vld1, busy, rom_en;
   logic [7:0] rdata, rom_data;
   logic [2:0] rom_addr;

   logic [7:0] rom_tbl [0:7] = '{8'h5A, 8'hC3, 8'h17, 8'hE8, 8'h99, 8'h26, 8'hF0, 8'h4B};

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   rom_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .gnt0(gnt0), .vld0(vld0),
      .req1(req1), .addr1(addr1), .gnt1(gnt1), .vld1(vld1),
      .rdata(rdata), .busy(busy), .rom_en(rom_en), .rom_addr(rom_addr),
      .rom_data(rom_data)
   );

   rom u_rom (.clk(clk), .en(rom_en), .addr(rom_addr), .data(rom_data));

   // Timeline model: cycle n is the period following the n-th rising edge.
   bit         m_gnt0 [0:N-1];
   bit         m_gnt1 [0:N-1];
   bit         m_vld0 [0:N-1];
   bit         m_vld1 [0:N-1];
   bit         m_en   [0:N-1];
   bit         m_busy [0:N-1];
   logic [7:0] m_rdata = 8'h00;
   logic [2:0] m_addr = 3'd0;
   bit         m_ptr = 1'b0;
   bit         model_on = 1'b0;
   int         free_cyc = 0;
   int         pend_cyc = -1;
   logic [7:0] pend_data = 8'h00;
   bit         pend_ptr = 1'b0;
   bit         w;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         model_on = 1'b1;
         for (int i = cyc; i < N; i++) begin
            m_gnt0[i] = 1'b0; m_gnt1[i] = 1'b0; m_vld0[i] = 1'b0;
            m_vld1[i] = 1'b0; m_en[i] = 1'b0; m_busy[i] = 1'b0;
         end
         m_rdata = 8'h00; m_addr = 3'd0; m_ptr = 1'b0;
         pend_cyc = -1; free_cyc = cyc;
      end else begin
         if (pend_cyc == cyc) begin
            m_rdata = pend_data; m_ptr = pend_ptr; pend_cyc = -1;
         end
         if (model_on && (cyc - 1 >= free_cyc) && (req0 || req1) && (cyc + 2 < N)) begin
            w = (req0 && req1) ? m_ptr : req1;
            m_addr = w ? addr1 : addr0;
            if (w) begin m_gnt1[cyc] = 1'b1; m_vld1[cyc+2] = 1'b1; end
            else   begin m_gnt0[cyc] = 1'b1; m_vld0[cyc+2] = 1'b1; end
            m_en[cyc] = 1'b1;
            m_busy[cyc] = 1'b1; m_busy[cyc+1] = 1'b1;
            pend_cyc = cyc + 2; pend_data = rom_tbl[m_addr]; pend_ptr = ~w;
            free_cyc = cyc + 2;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      fork
         begin : compare
            forever begin
               @(negedge clk);
               if (model_on && cyc < N) begin
                  chk("m_gnt0",  32'(gnt0),     32'(m_gnt0[cyc]));
                  chk("m_gnt1",  32'(gnt1),     32'(m_gnt1[cyc]));
                  chk("m_vld0",  32'(vld0),     32'(m_vld0[cyc]));
                  chk("m_vld1",  32'(vld1),     32'(m_vld1[cyc]));
                  chk("m_en",    32'(rom_en),   32'(m_en[cyc]));
                  chk("m_busy",  32'(busy),     32'(m_busy[cyc]));
                  chk("m_rdata", 32'(rdata),    32'(m_rdata));
                  chk("m_addr",  32'(rom_addr), 32'(m_addr));
               end
            end
         end
         begin : stimulus
            // Reset state
            step(2);
            chk("rst_gnt", 32'({gnt0, gnt1}), 0);
            chk("rst_vld", 32'({vld0, vld1}), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_en", 32'(rom_en), 0);
            chk("rst_rdata", 32'(rdata), 0);
            chk("rst_addr", 32'(rom_addr), 0);
            rst = 1'b0;

            // Single requester, address 2
            req0 = 1'b1; addr0 = 3'd2;
            step(1);
            chk("s_gnt0", 32'(gnt0), 1);
            chk("s_en", 32'(rom_en), 1);
            chk("s_addr", 32'(rom_addr), 2);
            req0 = 1'b0;
            step(1);
            chk("s_en_off", 32'(rom_en), 0);
            step(1);
            chk("s_vld0", 32'(vld0), 1);
            chk("s_rdata", 32'(rdata), 32'h17);
            chk("s_side1", 32'({gnt1, vld1}), 0);

            // Contention straight after reset
            rst = 1'b1;
            step(1);
            rst = 1'b0;
            req0 = 1'b1; addr0 = 3'd1; req1 = 1'b1; addr1 = 3'd6;
            for (int k = 0; k < 4; k++) begin
               step(1);
               if (k % 2 == 0) chk("c_gnt0", 32'({gnt0, gnt1}), 2);
               else            chk("c_gnt1", 32'({gnt0, gnt1}), 1);
               step(2);
               if (k % 2 == 0) chk("c_rdata0", 32'({vld0, vld1, rdata}), 32'h2C3);
               else            chk("c_rdata1", 32'({vld0, vld1, rdata}), 32'h1F0);
            end
            req0 = 1'b0; req1 = 1'b0;

            // Late request ignored while busy
            step(1);
            req0 = 1'b1; addr0 = 3'd5;
            step(1);
            chk("l_gnt0", 32'(gnt0), 1);
            req0 = 1'b0; req1 = 1'b1; addr1 = 3'd3;
            step(1);
            chk("l_nogrant_a", 32'(gnt1), 0);
            step(1);
            chk("l_nogrant_b", 32'(gnt1), 0);
            chk("l_rdata0", 32'({vld0, rdata}), 32'h126);
            step(1);
            chk("l_gnt1", 32'(gnt1), 1);
            req1 = 1'b0;
            step(2);
            chk("l_rdata1", 32'({vld1, rdata}), 32'h1E8);

            // Address sweep on requester 1
            for (int i = 0; i < 8; i++) begin
               req1 = 1'b1; addr1 = 3'(i);
               step(1);
               chk("w_gnt1", 32'(gnt1), 1);
               chk("w_addr", 32'(rom_addr), 32'(i));
               req1 = 1'b0;
               step(2);
               chk("w_vld1", 32'(vld1), 1);
               chk("w_rdata", 32'(rdata), 32'(rom_tbl[i]));
            end

            // Reset in CAPTURE abandons the access and re-favours requester 0
            step(1);
            req0 = 1'b1; addr0 = 3'd7;
            step(1);
            req0 = 1'b0;
            step(2);
            chk("r_pre", 32'({vld0, rdata}), 32'h14B);
            req0 = 1'b1; addr0 = 3'd4;
            step(1);
            chk("r_gnt0", 32'(gnt0), 1);
            req0 = 1'b0;
            step(1);
            rst = 1'b1;
            step(1);
            chk("r_busy", 32'(busy), 0);
            chk("r_rdata", 32'(rdata), 0);
            chk("r_en", 32'(rom_en), 0);
            chk("r_novld", 32'({vld0, vld1}), 0);
            rst = 1'b0;
            req0 = 1'b1; addr0 = 3'd0; req1 = 1'b1; addr1 = 3'd6;
            step(1);
            chk("r_first", 32'({gnt0, gnt1}), 2);
            req0 = 1'b0;
            step(3);
            chk("r_second", 32'({gnt0, gnt1}), 1);
            req1 = 1'b0;
            step(2);
            chk("r_rdata1", 32'({vld1, rdata}), 32'h1F0);

            // Idle for 20 cycles
            for (int i = 0; i < 20; i++) begin
               step(1);
               chk("i_quiet", 32'({rom_en, busy, gnt0, gnt1, vld0, vld1}), 0);
               chk("i_hold", 32'(rdata), 32'hF0);
            end
            step(1);
         end
      join_any
      disable fork;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares a single registered-read ROM (8 words x 8 bits, 3-bit address, enable-gated read) between two requesters.
- Round-robin arbitration, one outstanding ROM access at a time.
- Per-requester grant and read-valid handshake.
- Sits between client blocks and the `rom` instance. The arbiter is the only driver of the ROM's `en` and address inputs.

Parameters:
- ADDR_W, 3, ROM address width (depth = 2**ADDR_W).
- DATA_W, 8, ROM data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 access request; held until gnt0.
- addr0  input  ADDR_W  requester 0 read address; stable while req0 high.
- gnt0  output  1  one-cycle pulse: requester 0 request accepted.
- vld0  output  1  one-cycle pulse: rdata valid for requester 0.
- req1  input  1  requester 1 access request.
- addr1  input  ADDR_W  requester 1 read address.
- gnt1  output  1  one-cycle pulse: requester 1 accepted.
- vld1  output  1  one-cycle pulse: rdata valid for requester 1.
- rdata  output  DATA_W  read data, shared by both requesters, qualified by vld0/vld1.
- busy  output  1  high whenever the FSM is not IDLE.
- rom_en  output  1  ROM enable; high only in ISSUE.
- rom_addr  output  ADDR_W  ROM address.
- rom_data  input  DATA_W  ROM data; registered by the ROM one edge after en=1.

Behaviour:
- Reset (rst high at an edge):
  - FSM goes to IDLE.
  - gnt0, gnt1, vld0, vld1, rom_en and busy all become 0.
  - rdata and rom_addr become 0.
  - Round-robin pointer set to favour requester 0.
- FSM states: IDLE, ISSUE, CAPTURE. Fixed 3-cycle access.
- Cycle T, IDLE, at least one req high:
  - Winner chosen (see arbitration).
  - At the edge: gnt_winner<=1, rom_addr<=addr_winner, winner id latched, state->ISSUE.
  - No req: stay IDLE, all pulses 0.
- Cycle T+1, ISSUE:
  - rom_en=1 and rom_addr stable; the ROM captures at this edge.
  - gnt pulse is high in this cycle only.
  - state->CAPTURE.
- Cycle T+2, CAPTURE:
  - rom_data valid.
  - At the edge: rdata<=rom_data, vld_winner<=1, state->IDLE, pointer updated to favour the other requester.
- Cycle T+3:
  - vld_winner high for exactly one cycle.
  - FSM is in IDLE and may accept a new request in this same cycle.
  - Latency from req to vld is 3 cycles. Peak throughput is 1 access per 3 cycles.
- Arbitration:
  - Only one req high: it wins, regardless of pointer.
  - Both high: the favoured requester wins.
  - The pointer flips only when an access completes (CAPTURE edge).
- Request sampling:
  - req is sampled only in IDLE. req high during ISSUE/CAPTURE is ignored, not queued.
  - A requester still asserting req in the T+3 cycle is treated as a new request.
  - Requesters must drop req in the cycle gnt is seen if they want only one access.
- Data hold:
  - rdata holds its last value between accesses.
  - vld0 and vld1 are never high together. gnt0 and gnt1 are never high together.
- Address:
  - rom_addr holds its last value when idle.
  - Any address 0..2**ADDR_W-1 is legal; there is no wrap logic.
- rom_en is 0 in IDLE and CAPTURE, so there are no spurious ROM reads.
- Reset mid-operation (in ISSUE or CAPTURE):
  - The access is abandoned, with no vld for it.
  - Pointer returns to favour requester 0.
  - The next request after reset is serviced normally.
- Address changes after gnt have no effect; the address is latched in the IDLE->ISSUE edge.

Decomposition:
- Package rom_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum {IDLE, ISSUE, CAPTURE} in a 2-bit encoding.
  - Requester-id constants REQ0=0, REQ1=1.
- Sub-module rr_arb2:
  - Combinational 2-way round-robin pick.
  - Inputs: req[1:0], pointer. Output: one-hot winner.
  - Pointer register stays in rom_arbiter so that the update is tied to completion.
- Bench instantiates rom_arbiter and the existing `rom`; the expected rdata is the ROM contents at the address requested.

Test Plan:
- Single requester: req0=1, addr0=3'b010 at T, drop req0 after gnt0.
  - Required: gnt0 at T+1; rom_en=1 and rom_addr=2 at T+1; vld0 at T+3; rdata=ROM[2]; gnt1 and vld1 stay 0.
- Contention: req0=1/addr0=1 and req1=1/addr1=6, both held, starting right after reset.
  - Required grant order 0,1,0,1 at cycles T+1, T+4, T+7, T+10.
  - rdata alternates ROM[1], ROM[6].
- Late request ignored: req1 raised at T+1 while requester 0's access is busy.
  - Required: no gnt1 until T+4; vld1 at T+6.
- Address sweep: requester 1 reads addresses 0..7 back-to-back, each dropping req1 on gnt1.
  - Required: 8 vld1 pulses spaced 3 cycles apart; rdata matches ROM[0..7]; rom_addr wraps from 7 to 0 only via the input.
- Reset mid-access: assert rst in CAPTURE for 1 cycle.
  - Required: no vld; busy=0, rdata=0, rom_en=0 after the reset edge.
  - A following req1 and req0 pair is granted to 0 first.
- Idle check: no req for 20 cycles.
  - Required: rom_en, busy, gnt and vld all 0 throughout; rdata holds its previous value.
